// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-product vending controller.
// Accumulates nickel/dime/quarter credit (in nickel units) up to MAX_CREDIT.
// It vends one of N_PROD products, each with its own price and stock count.
// Change is paid out as a stream of nickel beats on a valid/ready handshake.
// Optional feature macro: VM_SALES_AUDIT_EN. When it is defined, o_sales_count
// is a saturating vend counter. When it is not defined, o_sales_count is 0.
//
// state  | meaning
// IDLE   | accepting coins, select and cancel
// VEND   | one-cycle dispense pulse on o_vend / o_vend_id
// CHANGE | paying out remaining credit one nickel per ready beat
module vending_machine_multi #(
   parameter int                         N_PROD     = 4,
   parameter int                         CREDIT_W   = 6,
   parameter logic [N_PROD*CREDIT_W-1:0] PRICES     = 24'h0C6105,
   parameter int                         MAX_CREDIT = 20,
   parameter int                         STOCK_W    = 4,
   parameter int                         STOCK_INIT = 4
) (
   input  logic                        i_clk,
   input  logic                        reset,
   input  logic                        i_nickle,
   input  logic                        i_dime,
   input  logic                        i_quarter,
   input  logic [N_PROD-1:0]           i_sel,
   input  logic                        i_cancel,
   input  logic                        i_restock,
   input  logic                        i_change_ready,
   output logic                        o_vend,
   output logic [$clog2(N_PROD)-1:0]   o_vend_id,
   output logic                        o_change_valid,
   output logic [CREDIT_W-1:0]         o_credit,
   output logic [N_PROD-1:0]           o_sold_out,
   output logic                        o_coin_reject,
   output logic                        o_sel_err,
   output logic                        o_busy,
   output logic [15:0]                 o_sales_count
);

   localparam int ID_W = $clog2(N_PROD);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_VEND   = 2'd1;
   localparam logic [1:0] S_CHANGE = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [STOCK_W-1:0]  stock_q [N_PROD];
   logic [STOCK_W-1:0]  stock_d [N_PROD];
   logic                vend_q, vend_d;
   logic [ID_W-1:0]     vend_id_q, vend_id_d;
   logic                coin_rej_q, coin_rej_d;
   logic                sel_err_q, sel_err_d;

   logic                any_coin;
   logic                extra_coin;
   logic [CREDIT_W:0]   coin_val;
   logic [CREDIT_W:0]   credit_sum;
   logic                sel_onehot;
   logic [ID_W-1:0]     sel_idx;
   logic [CREDIT_W-1:0] sel_price;
   logic [STOCK_W-1:0]  sel_stock;
   logic                accept;

   // Decode coin and select inputs into value, index, price and stock
   always_comb begin
      any_coin   = i_nickle | i_dime | i_quarter;
      extra_coin = i_nickle ? (i_dime | i_quarter) : (i_dime ? i_quarter : 1'b0);
      coin_val   = i_nickle ? (CREDIT_W+1)'(1) :
                   i_dime   ? (CREDIT_W+1)'(2) : (CREDIT_W+1)'(5);
      credit_sum = {1'b0, credit_q} + coin_val;
      sel_onehot = (i_sel != '0) && ((i_sel & (i_sel - N_PROD'(1))) == '0);
      sel_idx    = '0;
      sel_price  = '0;
      sel_stock  = '0;
      for (int k = 0; k < N_PROD; k++) begin
         if (i_sel[k]) begin
            sel_idx   = ID_W'(k);
            sel_price = PRICES[k*CREDIT_W +: CREDIT_W];
            sel_stock = stock_q[k];
         end
      end
   end

   // Next-state, credit, stock and pulse computation
   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      vend_d     = 1'b0;
      vend_id_d  = vend_id_q;
      coin_rej_d = 1'b0;
      sel_err_d  = 1'b0;
      accept     = 1'b0;
      for (int k = 0; k < N_PROD; k++) stock_d[k] = stock_q[k];

      case (state_q)
         S_IDLE: begin
            if (i_cancel) begin
               coin_rej_d = any_coin;
               if (credit_q != '0) state_d = S_CHANGE;
            end else if (any_coin) begin
               coin_rej_d = extra_coin;
               if (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT))
                  credit_d = credit_sum[CREDIT_W-1:0];
               else
                  coin_rej_d = 1'b1;
            end else if (i_sel != '0) begin
               if (!sel_onehot || sel_stock == '0 || credit_q < sel_price) begin
                  sel_err_d = 1'b1;
               end else begin
                  accept    = 1'b1;
                  credit_d  = credit_q - sel_price;
                  vend_d    = 1'b1;
                  vend_id_d = sel_idx;
                  state_d   = S_VEND;
               end
            end
         end
         S_VEND: begin
            coin_rej_d = any_coin;
            state_d    = (credit_q != '0) ? S_CHANGE : S_IDLE;
         end
         S_CHANGE: begin
            coin_rej_d = any_coin;
            if (i_change_ready && credit_q != '0) begin
               credit_d = credit_q - CREDIT_W'(1);
               if (credit_q == CREDIT_W'(1)) state_d = S_IDLE;
            end
            if (credit_q == '0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Restock wins over a same-cycle decrement
      for (int k = 0; k < N_PROD; k++) begin
         if (i_restock)
            stock_d[k] = STOCK_W'(STOCK_INIT);
         else if (accept && i_sel[k])
            stock_d[k] = stock_q[k] - STOCK_W'(1);
      end
   end

   // State and datapath registers
   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         credit_q   <= '0;
         vend_q     <= 1'b0;
         vend_id_q  <= '0;
         coin_rej_q <= 1'b0;
         sel_err_q  <= 1'b0;
         for (int k = 0; k < N_PROD; k++) stock_q[k] <= STOCK_W'(STOCK_INIT);
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         vend_q     <= vend_d;
         vend_id_q  <= vend_id_d;
         coin_rej_q <= coin_rej_d;
         sel_err_q  <= sel_err_d;
         for (int k = 0; k < N_PROD; k++) stock_q[k] <= stock_d[k];
      end
   end

   // Sold-out flags straight from the stock registers
   always_comb begin
      for (int k = 0; k < N_PROD; k++) o_sold_out[k] = (stock_q[k] == '0);
   end

   assign o_vend         = vend_q;
   assign o_vend_id      = vend_id_q;
   assign o_change_valid = (state_q == S_CHANGE);
   assign o_credit       = credit_q;
   assign o_coin_reject  = coin_rej_q;
   assign o_sel_err      = sel_err_q;
   assign o_busy         = (state_q != S_IDLE);

`ifdef VM_SALES_AUDIT_EN
   logic [15:0] sales_q, sales_d;

   // Count each dispense pulse, saturating at the top
   always_comb begin
      sales_d = sales_q;
      if (vend_q && sales_q != 16'hFFFF) sales_d = sales_q + 16'd1;
   end

   // Sales counter register, cleared only by reset
   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) sales_q <= 16'h0000;
      else       sales_q <= sales_d;
   end

   assign o_sales_count = sales_q;
`else
   assign o_sales_count = 16'h0000;
`endif

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
- Parametrised multi-product successor to the single-soda vending FSM.
- Accumulates nickel/dime/quarter credit up to a cap and vends one of N_PROD products with per-product prices and stock counts.
- Returns change as a stream of nickel beats over a valid/ready handshake.
- Sits between the coin acceptor front end and the dispenser/change-hopper drivers.

Parameters:
- N_PROD, 4: number of products; must be at least 2.
- CREDIT_W, 6: width of credit and price fields, in nickel units.
- PRICES, 24'h0C6105: packed N_PROD*CREDIT_W price vector, product 0 in the LSBs. Default prices in nickels are 5, 4, 6, 3 (25c, 20c, 30c, 15c).
- MAX_CREDIT, 20: credit cap in nickels (100c).
- STOCK_W, 4: width of each stock counter.
- STOCK_INIT, 4: stock loaded at reset and on restock.

Ports:
- i_clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- i_nickle, in, 1: 5c coin, one-cycle pulse.
- i_dime, in, 1: 10c coin, one-cycle pulse.
- i_quarter, in, 1: 25c coin, one-cycle pulse.
- i_sel, in, N_PROD: one-hot product select pulse.
- i_cancel, in, 1: refund request pulse.
- i_restock, in, 1: reload all stock counters to STOCK_INIT.
- i_change_ready, in, 1: hopper accepts one nickel.
- o_vend, out, 1: one-cycle dispense pulse.
- o_vend_id, out, $clog2(N_PROD): product index, valid while o_vend is high.
- o_change_valid, out, 1: one nickel of change is pending.
- o_credit, out, CREDIT_W: current credit in nickels.
- o_sold_out, out, N_PROD: per-product bit, high when that product's stock is 0.
- o_coin_reject, out, 1: one-cycle pulse; the coin was not credited and must be physically returned.
- o_sel_err, out, 1: one-cycle pulse; the select was refused.
- o_busy, out, 1: high in the VEND and CHANGE states.
- o_sales_count, out, 16: vend counter (see Optional Feature).

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE and credit to 0.
  - Every stock counter loads STOCK_INIT.
  - All pulse outputs, o_change_valid and o_sales_count go to 0.
  - Reset during VEND or CHANGE discards the remaining credit; no change is owed after reset.
- Outputs are registered; o_sold_out and o_credit reflect register contents.
- States:
  - IDLE: accepts coins, select and cancel.
  - VEND: lasts exactly one cycle with o_vend=1 and o_vend_id set.
  - CHANGE: o_change_valid=1 until credit reaches 0.
- IDLE priority order, one action per cycle: cancel, then coin, then select.
  - cancel: if credit>0, go to CHANGE; if credit==0, no-op. Any coin in the same cycle is rejected.
  - Coin priority is nickel > dime > quarter. Only the highest-priority asserted coin is considered; other coins asserted in the same cycle pulse o_coin_reject.
  - A considered coin is credited only if credit+value <= MAX_CREDIT; otherwise o_coin_reject pulses and credit is unchanged.
  - A select in the same cycle as a coin or cancel is ignored silently (no o_sel_err).
  - select for product k, valid only when i_sel is one-hot:
    - Refused with o_sel_err=1 and no state change if stock[k]==0 or credit < PRICES[k].
    - Otherwise: credit -= price, stock[k] -= 1, go to VEND with o_vend_id=k.
    - A non-one-hot i_sel (more than one bit set) also gives o_sel_err=1.
- VEND to next state, after one cycle:
  - If credit>0, go to CHANGE.
  - Otherwise go to IDLE.
  - Latency from accepted select to o_vend is 1 cycle.
- CHANGE:
  - Each cycle with o_change_valid && i_change_ready decrements credit by 1.
  - The beat that takes credit from 1 to 0 moves the FSM to IDLE; o_change_valid is low on the next cycle.
  - With i_change_ready held low, o_change_valid stays high indefinitely.
- Coins arriving in VEND or CHANGE: o_coin_reject=1, credit unchanged. Selects and cancels in these states are ignored.
- i_restock in any state sets all stocks to STOCK_INIT and takes precedence over a same-cycle decrement.
- Credit never exceeds MAX_CREDIT and never underflows.

Optional Feature:
- Macro VM_SALES_AUDIT_EN.
- Defined: o_sales_count increments by 1 on every o_vend pulse and saturates at 16'hFFFF. It is cleared only by reset; restock does not clear it.
- Undefined: o_sales_count is tied to 16'h0000 and the counter logic is absent. All other behaviour is identical.

Test Plan:
- Quarter then select product 0 (price 5): credit goes to 5, then 0. o_vend=1 with o_vend_id=0 one cycle after the select; no CHANGE state entered.
- Quarter and dime, then select product 3 (price 3): o_vend with id 3, then CHANGE with 4 beats. Hold i_change_ready low for 3 cycles mid-stream: o_change_valid holds, credit drops 4→0 only on ready beats.
- Four quarters (credit 20), then a nickel: o_coin_reject=1, credit stays 20. Then cancel: exactly 20 change beats, return to IDLE.
- Dime with credit 0, then select product 2 (price 6): o_sel_err=1, credit stays 2. Nickel and dime asserted in the same cycle: credit becomes 3 and o_coin_reject=1 for the dime.
- Vend product 1 five times with STOCK_INIT=4: the fifth select gives o_sel_err and o_sold_out[1]=1. i_restock clears o_sold_out[1]; the next vend succeeds.
- Assert reset during CHANGE with credit 7: o_change_valid=0 and credit 0 immediately (asynchronous), all stocks back to 4. With VM_SALES_AUDIT_EN defined, o_sales_count returns to 0.
